pll_reset_sequencer: RTL and testbench

Supervises a Gowin rPLL from its reference-clock domain. It holds the PLL in reset after power-up and then waits for LOCK, with a timeout. LOCK must stay stable before the block releases NUM_CH downstream resets one after another. Lock loss triggers a re-sequence, and repeated failures latch a fault. The block sits between the board oscillator/rPLL wrapper and the reset synchronisers of each generated clock domain.

---
 rtl/pll_reset_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// Power-up and lock supervisor for a Gowin rPLL, clocked from the free-running reference clock.
// Holds the PLL in reset, waits for a stable LOCK, then releases downstream resets one at a time.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 256,
  parameter int NUM_CH        = 2,
  parameter int STAGGER       = 8,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                      clkin,
  input  logic                      reset_n,
  input  logic                      lock_i,
  input  logic                      retry_i,
  output logic                      pll_reset_o,
  output logic [NUM_CH-1:0]         rst_n_o,
  output logic                      ready_o,
  output logic                      fault_o,
  output logic [2:0]                state_o,
  output logic [((MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1) - 1:0] retry_cnt_o
);

  localparam int RC_W        = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int SPAN        = (NUM_CH - 1) * STAGGER;
  localparam int MAX_A       = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B       = (STABLE_CYCLES > SPAN) ? STABLE_CYCLES : SPAN;
  localparam int CNT_MAX     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W       = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pll_reset_q, pll_reset_d;
  logic [NUM_CH-1:0]   rst_n_q, rst_n_d;
  logic                ready_q, ready_d;
  logic                fault_q, fault_d;
  logic [RC_W-1:0]     retry_cnt_q, retry_cnt_d;
  logic                lock_meta, lock_s;
  logic                fail;

  // LOCK comes from the PLL and is asynchronous to clkin.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= lock_i;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      pll_reset_q <= 1'b1;
      rst_n_q     <= '0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      retry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_reset_q <= pll_reset_d;
      rst_n_q     <= rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  // Next-state and next-output logic; a failed attempt is folded in after the case.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pll_reset_d = pll_reset_q;
    rst_n_d     = rst_n_q;
    ready_d     = ready_q;
    fault_d     = fault_q;
    retry_cnt_d = retry_cnt_q;
    fail        = 1'b0;

    case (state_q)
      S_RESET_PLL: begin
        pll_reset_d = 1'b1;
        rst_n_d     = '0;
        ready_d     = 1'b0;
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d     = S_WAIT_LOCK;
          cnt_d       = '0;
          pll_reset_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT_LOCK: begin
        pll_reset_d = 1'b0;
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STABLE: begin
        if (!lock_s) begin
          fail = 1'b1;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RELEASE: begin
        if (!lock_s) begin
          fail = 1'b1;
        end else begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (cnt_q == CNT_W'(k * STAGGER)) rst_n_d[k] = 1'b1;
          end
          // The last channel rising is also the entry into RUN.
          if (cnt_q == CNT_W'(SPAN)) begin
            state_d     = S_RUN;
            cnt_d       = '0;
            ready_d     = 1'b1;
            retry_cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_RUN: begin
        if (!lock_s) fail = 1'b1;
      end

      S_FAULT: begin
        pll_reset_d = 1'b1;
        rst_n_d     = '0;
        fault_d     = 1'b1;
        if (retry_i) begin
          state_d     = S_RESET_PLL;
          cnt_d       = '0;
          fault_d     = 1'b0;
          retry_cnt_d = '0;
        end
      end

      default: begin
        state_d     = S_RESET_PLL;
        cnt_d       = '0;
        pll_reset_d = 1'b1;
        rst_n_d     = '0;
        ready_d     = 1'b0;
        fault_d     = 1'b0;
      end
    endcase

    if (fail) begin
      rst_n_d     = '0;
      ready_d     = 1'b0;
      cnt_d       = '0;
      pll_reset_d = 1'b1;
      if (retry_cnt_q == RC_W'(MAX_RETRIES)) begin
        state_d = S_FAULT;
        fault_d = 1'b1;
      end else begin
        state_d     = S_RESET_PLL;
        retry_cnt_d = retry_cnt_q + RC_W'(1);
      end
    end
  end

  assign pll_reset_o = pll_reset_q;
  assign rst_n_o     = rst_n_q;
  assign ready_o     = ready_q;
  assign fault_o     = fault_q;
  assign state_o     = state_q;
  assign retry_cnt_o = retry_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed scoreboard bench for pll_reset_sequencer: one instance with MAX_RETRIES=2,
// a second with MAX_RETRIES=0 for the straight-to-FAULT case.
module tb_pll_reset_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 5;
  localparam int NUM_CH        = 3;
  localparam int STAGGER       = 2;

  logic clkin = 1'b0;
  always #5 clkin = ~clkin;

  logic              reset_n, lock_i, retry_i;
  logic              pll_reset;
  logic [NUM_CH-1:0] rst_n;
  logic              ready, fault;
  logic [2:0]        state;
  logic [1:0]        retry_cnt;

  logic              reset_n0, lock0, retry0;
  logic              pll_reset0;
  logic [NUM_CH-1:0] rst_n0;
  logic              ready0, fault0;
  logic [2:0]        state0;
  logic [0:0]        retry_cnt0;

  pll_reset_sequencer #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .STABLE_CYCLES(STABLE_CYCLES),
    .NUM_CH(NUM_CH), .STAGGER(STAGGER), .MAX_RETRIES(2)
  ) u_dut (
    .clkin(clkin), .reset_n(reset_n), .lock_i(lock_i), .retry_i(retry_i),
    .pll_reset_o(pll_reset), .rst_n_o(rst_n), .ready_o(ready), .fault_o(fault),
    .state_o(state), .retry_cnt_o(retry_cnt)
  );

  pll_reset_sequencer #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .STABLE_CYCLES(STABLE_CYCLES),
    .NUM_CH(NUM_CH), .STAGGER(STAGGER), .MAX_RETRIES(0)
  ) u_dut0 (
    .clkin(clkin), .reset_n(reset_n0), .lock_i(lock0), .retry_i(retry0),
    .pll_reset_o(pll_reset0), .rst_n_o(rst_n0), .ready_o(ready0), .fault_o(fault0),
    .state_o(state0), .retry_cnt_o(retry_cnt0)
  );

  typedef struct {
    string       tag;
    logic [10:0] exp;
    bit          sel;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Packs {state, pll_reset, rst_n, ready, fault, retry_cnt} for one-shot comparison.
  function automatic logic [10:0] mk(input logic [2:0] st, input logic pll, input logic [2:0] rn,
                                     input logic rdy, input logic flt, input logic [1:0] rc);
    return {st, pll, rn, rdy, flt, rc};
  endfunction

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clkin);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [10:0] obs;
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_empty");
      return;
    end
    e   = sb.pop_front();
    obs = e.sel ? {state0, pll_reset0, rst_n0, ready0, fault0, 1'b0, retry_cnt0}
                : {state, pll_reset, rst_n, ready, fault, retry_cnt};
    vectors++;
    assert (obs === e.exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic expectAfter(input int cycles, input string tag, input logic [10:0] exp,
                             input bit sel);
    sb.push_back('{tag: tag, exp: exp, sel: sel});
    applyStimulus(cycles);
    checkOutput();
  endtask

  // Holds reset for two cycles, checks the reset values, then releases on a falling edge.
  task automatic doReset(input logic lk, input string tag);
    reset_n = 1'b0;
    lock_i  = lk;
    retry_i = 1'b0;
    expectAfter(2, tag, mk(3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0), 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    lock_i   = 1'b0;
    retry_i  = 1'b0;
    reset_n0 = 1'b0;
    lock0    = 1'b0;
    retry0   = 1'b0;
    applyStimulus(1);

    $display("[TB] normal bring-up");
    doReset(1'b0, "t1_reset_values");
    expectAfter(3, "t1_rst_hold",  mk(3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0), 1'b0);
    expectAfter(1, "t1_wait",      mk(3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0), 1'b0);
    applyStimulus(6);
    lock_i = 1'b1;
    expectAfter(2, "t1_wait_sync", mk(3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0), 1'b0);
    expectAfter(1, "t1_stable",    mk(3'd2, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0), 1'b0);
    expectAfter(5, "t1_release",   mk(3'd3, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0), 1'b0);
    expectAfter(1, "t1_ch0",       mk(3'd3, 1'b0, 3'b001, 1'b0, 1'b0, 2'd0), 1'b0);
    expectAfter(1, "t1_ch0_hold",  mk(3'd3, 1'b0, 3'b001, 1'b0, 1'b0, 2'd0), 1'b0);
    expectAfter(1, "t1_ch1",       mk(3'd3, 1'b0, 3'b011, 1'b0, 1'b0, 2'd0), 1'b0);
    expectAfter(1, "t1_ch1_hold",  mk(3'd3, 1'b0, 3'b011, 1'b0, 1'b0, 2'd0), 1'b0);
    expectAfter(1, "t1_run",       mk(3'd4, 1'b0, 3'b111, 1'b1, 1'b0, 2'd0), 1'b0);
    expectAfter(5, "t1_run_hold",  mk(3'd4, 1'b0, 3'b111, 1'b1, 1'b0, 2'd0), 1'b0);

    $display("[TB] lock timeout into fault");
    doReset(1'b0, "t2_reset_values");
    retry_i = 1'b1;
    applyStimulus(1);
    retry_i = 1'b0;
    expectAfter(22, "t2_wait1",    mk(3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0), 1'b0);
    expectAfter(1,  "t2_fail1",    mk(3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd1), 1'b0);
    expectAfter(23, "t2_wait2",    mk(3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1), 1'b0);
    expectAfter(1,  "t2_fail2",    mk(3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd2), 1'b0);
    expectAfter(23, "t2_wait3",    mk(3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd2), 1'b0);
    expectAfter(1,  "t2_fault",    mk(3'd5, 1'b1, 3'b000, 1'b0, 1'b1, 2'd2), 1'b0);
    expectAfter(10, "t2_fault_hold", mk(3'd5, 1'b1, 3'b000, 1'b0, 1'b1, 2'd2), 1'b0);

    $display("[TB] fault recovery");
    lock_i  = 1'b1;
    retry_i = 1'b1;
    expectAfter(1, "t3_retry",     mk(3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0), 1'b0);
    retry_i = 1'b0;
    expectAfter(4, "t3_wait",      mk(3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0), 1'b0);
    expectAfter(1, "t3_stable",    mk(3'd2, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0), 1'b0);
    expectAfter(5, "t3_release",   mk(3'd3, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0), 1'b0);
    expectAfter(4, "t3_ch1",       mk(3'd3, 1'b0, 3'b011, 1'b0, 1'b0, 2'd0), 1'b0);
    expectAfter(1, "t3_run",       mk(3'd4, 1'b0, 3'b111, 1'b1, 1'b0, 2'd0), 1'b0);

    $display("[TB] unstable lock");
    doReset(1'b1, "t4_reset_values");
    expectAfter(5, "t4_stable",    mk(3'd2, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0), 1'b0);
    applyStimulus(1);
    lock_i = 1'b0;
    expectAfter(2, "t4_stable_lag", mk(3'd2, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0), 1'b0);
    lock_i = 1'b1;
    expectAfter(1, "t4_fail",      mk(3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd1), 1'b0);
    expectAfter(4, "t4_wait",      mk(3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1), 1'b0);
    expectAfter(1, "t4_stable2",   mk(3'd2, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1), 1'b0);
    expectAfter(10, "t4_run",      mk(3'd4, 1'b0, 3'b111, 1'b1, 1'b0, 2'd0), 1'b0);

    $display("[TB] lock loss during release");
    doReset(1'b1, "t5_reset_values");
    expectAfter(10, "t5_release",  mk(3'd3, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0), 1'b0);
    lock_i = 1'b0;
    expectAfter(1, "t5_ch0",       mk(3'd3, 1'b0, 3'b001, 1'b0, 1'b0, 2'd0), 1'b0);
    expectAfter(1, "t5_ch0_lag",   mk(3'd3, 1'b0, 3'b001, 1'b0, 1'b0, 2'd0), 1'b0);
    expectAfter(1, "t5_fail",      mk(3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd1), 1'b0);

    $display("[TB] lock loss in run");
    doReset(1'b1, "t5r_reset_values");
    expectAfter(15, "t5_run",      mk(3'd4, 1'b0, 3'b111, 1'b1, 1'b0, 2'd0), 1'b0);
    lock_i = 1'b0;
    expectAfter(2, "t5_run_lag",   mk(3'd4, 1'b0, 3'b111, 1'b1, 1'b0, 2'd0), 1'b0);
    expectAfter(1, "t5_run_fail",  mk(3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd1), 1'b0);
    lock_i = 1'b1;
    expectAfter(4, "t5_rewait",    mk(3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1), 1'b0);
    expectAfter(1, "t5_restable",  mk(3'd2, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1), 1'b0);
    expectAfter(10, "t5_rerun",    mk(3'd4, 1'b0, 3'b111, 1'b1, 1'b0, 2'd0), 1'b0);

    $display("[TB] asynchronous reset mid-release");
    doReset(1'b1, "t6_reset_values");
    expectAfter(11, "t6_ch0",      mk(3'd3, 1'b0, 3'b001, 1'b0, 1'b0, 2'd0), 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    sb.push_back('{tag: "t6_async_reset", exp: mk(3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0), sel: 1'b0});
    checkOutput();
    applyStimulus(1);
    reset_n = 1'b1;

    $display("[TB] zero-retry instance");
    expectAfter(1, "r0_reset_values", mk(3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0), 1'b1);
    reset_n0 = 1'b1;
    expectAfter(23, "r0_wait",     mk(3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0), 1'b1);
    expectAfter(1,  "r0_fault",    mk(3'd5, 1'b1, 3'b000, 1'b0, 1'b1, 2'd0), 1'b1);
    retry0 = 1'b1;
    expectAfter(1,  "r0_retry",    mk(3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0), 1'b1);
    retry0 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
